alu_issue_ctrl: RTL and testbench

- Issue/sequencing front end that drives the ALU's ctrl/A/B inputs and consumes its Res and ZF/NF/EF/GF/LF outputs.
- Accepts 32-bit ALU instruction words over a valid/ready handshake and reads operands from an internal 8x32 register file.
- Drives the combinational ALU, captures its result and flags, writes the result back, and presents result plus flags downstream through a second valid/ready handshake.

---
 rtl/alu_issue_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_ctrl.sv
// Issue/sequencing front end for a combinational ALU: decode, operand fetch, capture, writeback.
// Optional performance counters are compiled in with `define ALU_ISSUE_PERF_EN.
module alu_issue_ctrl #(
  parameter  int NREGS = 8,
  parameter  int IMM_W = 18,
  localparam int RW    = $clog2(NREGS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [31:0]   in_instr,
  output logic [3:0]    alu_ctrl,
  output logic [31:0]   alu_a,
  output logic [31:0]   alu_b,
  input  logic [31:0]   alu_res,
  input  logic          alu_zf,
  input  logic          alu_nf,
  input  logic          alu_ef,
  input  logic          alu_gf,
  input  logic          alu_lf,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [31:0]   out_res,
  output logic [4:0]    out_flags,
  output logic [RW-1:0] out_rd,
  output logic          out_illegal
`ifdef ALU_ISSUE_PERF_EN
  ,
  output logic [31:0]   perf_retired,
  output logic [31:0]   perf_illegal
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_DECODE, S_EXEC, S_WB} state_t;

  state_t          state_q, state_d;
  logic [31:0]     instr_q, instr_d;
  logic [3:0]      alu_ctrl_q, alu_ctrl_d;
  logic [31:0]     alu_a_q, alu_a_d;
  logic [31:0]     alu_b_q, alu_b_d;
  logic [31:0]     out_res_q, out_res_d;
  logic [4:0]      out_flags_q, out_flags_d;
  logic [RW-1:0]   out_rd_q, out_rd_d;
  logic            out_illegal_q, out_illegal_d;
  logic            out_valid_q, out_valid_d;
  logic            in_ready_q, in_ready_d;
  logic            first_wb_q, first_wb_d;
  logic            wb_we;
  logic [31:0]     regs_q [NREGS];
  logic [31:0]     regs_d [NREGS];
  logic [31:0]     rf_view [NREGS];

  logic [3:0]      opcode;
  logic [RW-1:0]   fld_rd, fld_rs1, fld_rs2;
  logic            imm_sel;
  logic [31:0]     imm_ext;
  logic            illegal;

  assign opcode  = instr_q[31:28];
  assign fld_rd  = instr_q[27:25];
  assign fld_rs1 = instr_q[24:22];
  assign fld_rs2 = instr_q[21:19];
  assign imm_sel = instr_q[IMM_W];
  assign imm_ext = {{(32-IMM_W){instr_q[IMM_W-1]}}, instr_q[IMM_W-1:0]};
  assign illegal = (opcode >= 4'd10);

  // R0 is hardwired to zero on the read side; writes to it are suppressed too.
  genvar gi;
  generate
    for (gi = 0; gi < NREGS; gi++) begin : g_rf_view
      if (gi == 0) begin : g_zero
        assign rf_view[gi] = '0;
      end else begin : g_reg
        assign rf_view[gi] = regs_q[gi];
      end
    end
  endgenerate

  always_comb begin
    state_d       = state_q;
    instr_d       = instr_q;
    alu_ctrl_d    = alu_ctrl_q;
    alu_a_d       = alu_a_q;
    alu_b_d       = alu_b_q;
    out_res_d     = out_res_q;
    out_flags_d   = out_flags_q;
    out_rd_d      = out_rd_q;
    out_illegal_d = out_illegal_q;
    first_wb_d    = first_wb_q;
    wb_we         = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          instr_d = in_instr;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        alu_ctrl_d = opcode;
        alu_a_d    = rf_view[fld_rs1];
        alu_b_d    = imm_sel ? imm_ext : rf_view[fld_rs2];
        state_d    = S_EXEC;
      end
      S_EXEC: begin
        out_res_d     = illegal ? '0 : alu_res;
        out_flags_d   = illegal ? '0 : {alu_zf, alu_nf, alu_ef, alu_gf, alu_lf};
        out_rd_d      = fld_rd;
        out_illegal_d = illegal;
        first_wb_d    = 1'b1;
        state_d       = S_WB;
      end
      S_WB: begin
        first_wb_d = 1'b0;
        wb_we      = first_wb_q && !out_illegal_q && (out_rd_q != '0);
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    in_ready_d  = (state_d == S_IDLE);
    out_valid_d = (state_d == S_WB);
  end

  always_comb begin
    for (int i = 0; i < NREGS; i++) regs_d[i] = regs_q[i];
    if (wb_we) regs_d[out_rd_q] = out_res_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      instr_q       <= '0;
      alu_ctrl_q    <= '0;
      alu_a_q       <= '0;
      alu_b_q       <= '0;
      out_res_q     <= '0;
      out_flags_q   <= '0;
      out_rd_q      <= '0;
      out_illegal_q <= 1'b0;
      out_valid_q   <= 1'b0;
      in_ready_q    <= 1'b1;
      first_wb_q    <= 1'b0;
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else begin
      state_q       <= state_d;
      instr_q       <= instr_d;
      alu_ctrl_q    <= alu_ctrl_d;
      alu_a_q       <= alu_a_d;
      alu_b_q       <= alu_b_d;
      out_res_q     <= out_res_d;
      out_flags_q   <= out_flags_d;
      out_rd_q      <= out_rd_d;
      out_illegal_q <= out_illegal_d;
      out_valid_q   <= out_valid_d;
      in_ready_q    <= in_ready_d;
      first_wb_q    <= first_wb_d;
      for (int i = 0; i < NREGS; i++) regs_q[i] <= regs_d[i];
    end
  end

  assign in_ready    = in_ready_q;
  assign alu_ctrl    = alu_ctrl_q;
  assign alu_a       = alu_a_q;
  assign alu_b       = alu_b_q;
  assign out_valid   = out_valid_q;
  assign out_res     = out_res_q;
  assign out_flags   = out_flags_q;
  assign out_rd      = out_rd_q;
  assign out_illegal = out_illegal_q;

`ifdef ALU_ISSUE_PERF_EN
  logic [31:0] perf_retired_q, perf_retired_d;
  logic [31:0] perf_illegal_q, perf_illegal_d;

  always_comb begin
    perf_retired_d = perf_retired_q;
    perf_illegal_d = perf_illegal_q;
    if (out_valid_q && out_ready) begin
      if (out_illegal_q) perf_illegal_d = perf_illegal_q + 32'd1;
      else               perf_retired_d = perf_retired_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_retired_q <= '0;
      perf_illegal_q <= '0;
    end else begin
      perf_retired_q <= perf_retired_d;
      perf_illegal_q <= perf_illegal_d;
    end
  end

  assign perf_retired = perf_retired_q;
  assign perf_illegal = perf_illegal_q;
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a behavioural ALU, register model and result scoreboard.
module tb_alu_issue_ctrl;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  flags;
    logic [2:0]  rd;
    logic        ill;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [3:0]  alu_ctrl;
  logic [31:0] alu_a, alu_b, alu_res;
  logic [4:0]  alu_fl;
  logic        out_valid, out_ready;
  logic [31:0] out_res;
  logic [4:0]  out_flags;
  logic [2:0]  out_rd;
  logic        out_illegal;
`ifdef ALU_ISSUE_PERF_EN
  logic [31:0] perf_retired, perf_illegal;
`endif

  int          checks = 0;
  int          errors = 0;
  exp_t        sb[$];
  logic [31:0] regm [8];
  logic [31:0] last_res;
  logic [4:0]  last_flags;
  logic [2:0]  last_rd;
  logic        last_ill;
  int          exp_ret = 0;
  int          exp_ill = 0;

  always #5 clk = ~clk;

  alu_issue_ctrl dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .alu_ctrl(alu_ctrl), .alu_a(alu_a), .alu_b(alu_b), .alu_res(alu_res),
    .alu_zf(alu_fl[4]), .alu_nf(alu_fl[3]), .alu_ef(alu_fl[2]),
    .alu_gf(alu_fl[1]), .alu_lf(alu_fl[0]),
    .out_valid(out_valid), .out_ready(out_ready), .out_res(out_res),
    .out_flags(out_flags), .out_rd(out_rd), .out_illegal(out_illegal)
`ifdef ALU_ISSUE_PERF_EN
    , .perf_retired(perf_retired), .perf_illegal(perf_illegal)
`endif
  );

  // Behavioural ALU: compare flags are only meaningful for Sub; illegal opcodes return 0.
  function automatic logic [36:0] alu_f(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    logic e, g, l;
    e = 1'b0; g = 1'b0; l = 1'b0;
    case (c)
      4'd0: r = a + b;
      4'd1: begin
        r = a - b;
        e = (a == b);
        g = ($signed(a) > $signed(b));
        l = ($signed(a) < $signed(b));
      end
      4'd2: r = a << b[4:0];
      4'd3: r = a >> b[4:0];
      4'd4: r = a & b;
      4'd5: r = a | b;
      4'd6: r = a ^ b;
      4'd7: r = ~(a & b);
      4'd8: r = ~a;
      4'd9: r = ~(a | b);
      default: r = '0;
    endcase
    return {r, (r == 32'd0), r[31], e, g, l};
  endfunction

  always_comb {alu_res, alu_fl} = alu_f(alu_ctrl, alu_a, alu_b);

  function automatic logic [31:0] mk(input int op, input int rd, input int rs1, input int rs2,
                                     input int isel, input logic [17:0] imm);
    logic [31:0] w;
    w = {op[3:0], rd[2:0], rs1[2:0], rs2[2:0], isel[0], imm};
    return w;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset;
    for (int i = 0; i < 8; i++) regm[i] = '0;
    sb.delete();
    exp_ret = 0;
    exp_ill = 0;
  endtask

  task automatic send(input logic [31:0] w);
    exp_t        e;
    logic [31:0] a, b;
    logic [36:0] rf;
    logic        hs;
    a  = (w[24:22] == 3'd0) ? 32'd0 : regm[w[24:22]];
    b  = w[18] ? {{14{w[17]}}, w[17:0]} : ((w[21:19] == 3'd0) ? 32'd0 : regm[w[21:19]]);
    rf = alu_f(w[31:28], a, b);
    e.rd  = w[27:25];
    e.ill = (w[31:28] >= 4'd10);
    e.res   = e.ill ? 32'd0 : rf[36:5];
    e.flags = e.ill ? 5'd0 : rf[4:0];
    if (!e.ill && e.rd != 3'd0) regm[e.rd] = e.res;
    sb.push_back(e);
    in_valid = 1'b1;
    in_instr = w;
    hs = 1'b0;
    for (int i = 0; i < 20; i++) begin
      hs = in_ready;
      tick;
      if (hs) break;
    end
    in_valid = 1'b0;
    chk("accept", {31'd0, hs}, 32'd1);
  endtask

  task automatic recv(input int hold, input bit overlap, input logic [31:0] nxt);
    exp_t e;
    int   lat;
    lat = 1;
    for (int i = 0; i < 20 && !out_valid; i++) begin
      tick;
      lat++;
    end
    chk("latency", lat, 3);
    chk("sb_size", sb.size(), 1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("out_res", out_res, e.res);
      chk("out_flags", {27'd0, out_flags}, {27'd0, e.flags});
      chk("out_rd", {29'd0, out_rd}, {29'd0, e.rd});
      chk("out_illegal", {31'd0, out_illegal}, {31'd0, e.ill});
      chk("wb_in_ready", {31'd0, in_ready}, 32'd0);
      for (int i = 0; i < hold; i++) begin
        out_ready = 1'b0;
        tick;
        chk("stall_valid", {31'd0, out_valid}, 32'd1);
        chk("stall_res", out_res, e.res);
        chk("stall_flags", {27'd0, out_flags}, {27'd0, e.flags});
        chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
      end
      last_res   = out_res;
      last_flags = out_flags;
      last_rd    = out_rd;
      last_ill   = out_illegal;
      $display("txn rd=%0d res=%08h flags=%05b illegal=%0d latency=%0d hold=%0d",
               out_rd, out_res, out_flags, out_illegal, lat, hold);
      if (e.ill) exp_ill++; else exp_ret++;
    end
    out_ready = 1'b1;
    if (overlap) begin
      in_valid = 1'b1;
      in_instr = nxt;
    end
    tick;
    out_ready = 1'b0;
    chk("post_out_valid", {31'd0, out_valid}, 32'd0);
    chk("post_in_ready", {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_instr  = '0;
    out_ready = 1'b0;
    last_res = '0; last_flags = '0; last_rd = '0; last_ill = 1'b0;
    model_reset();
    tick; tick; tick;
    rst = 1'b0;
    tick;

    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_res", out_res, 32'd0);
    chk("rst_out_flags", {27'd0, out_flags}, 32'd0);
    chk("rst_out_rd", {29'd0, out_rd}, 32'd0);
    chk("rst_out_illegal", {31'd0, out_illegal}, 32'd0);
    chk("rst_alu_ctrl", {28'd0, alu_ctrl}, 32'd0);
    chk("rst_alu_a", alu_a, 32'd0);
    chk("rst_alu_b", alu_b, 32'd0);

    // Add r1 = r0 + 5, then read r1 back.
    send(mk(0, 1, 0, 0, 1, 18'd5)); recv(0, 0, 0);
    chk("add5_res", last_res, 32'd5);
    chk("add5_flags", {27'd0, last_flags}, 32'd0);
    chk("add5_rd", {29'd0, last_rd}, 32'd1);
    send(mk(0, 7, 1, 0, 1, 18'd0)); recv(0, 0, 0);
    chk("read_r1", last_res, 32'd5);

    // Sub of equal operands.
    send(mk(0, 2, 0, 0, 1, 18'd7)); recv(0, 0, 0);
    send(mk(0, 3, 0, 0, 1, 18'd7)); recv(0, 0, 0);
    send(mk(1, 4, 2, 3, 0, 18'd0)); recv(0, 0, 0);
    chk("sub_res", last_res, 32'd0);
    chk("sub_flags", {27'd0, last_flags}, 32'h14);

    // Illegal opcode: no writeback to r5.
    send(mk(12, 5, 2, 0, 1, 18'd3)); recv(0, 0, 0);
    chk("ill_flag", {31'd0, last_ill}, 32'd1);
    chk("ill_res", last_res, 32'd0);
    chk("ill_flags", {27'd0, last_flags}, 32'd0);
    send(mk(0, 7, 5, 0, 1, 18'd0)); recv(0, 0, 0);
    chk("r5_unchanged", last_res, 32'd0);

    // Downstream stall for 6 cycles.
    send(mk(6, 3, 2, 4, 0, 18'd0)); recv(6, 0, 0);
    chk("stall_xor_res", last_res, 32'd7);

    // Sign-extended immediate, then logical shift right.
    send(mk(0, 1, 0, 0, 1, 18'h3FFFF)); recv(0, 0, 0);
    chk("neg1_res", last_res, 32'hFFFF_FFFF);
    chk("neg1_flags", {27'd0, last_flags}, 32'h08);
    send(mk(3, 2, 1, 0, 1, 18'd4)); recv(0, 0, 0);
    chk("sr_res", last_res, 32'h0FFF_FFFF);

    // in_valid raised together with out_ready in WB must not be accepted in that cycle.
    send(mk(2, 5, 2, 0, 1, 18'd3)); recv(0, 1, mk(8, 6, 5, 0, 0, 18'd0));
    chk("sl_res", last_res, 32'h7FFF_FFF8);
    send(mk(8, 6, 5, 0, 0, 18'd0)); recv(1, 0, 0);
    chk("not_res", last_res, 32'h8000_0007);

    for (int k = 0; k < 8; k++) begin
      send(mk($urandom_range(0, 9), $urandom_range(0, 7), $urandom_range(0, 7),
              $urandom_range(0, 7), $urandom_range(0, 1), 18'($urandom)));
      recv($urandom_range(0, 2), 0, 0);
    end

`ifdef ALU_ISSUE_PERF_EN
    chk("perf_retired", perf_retired, exp_ret);
    chk("perf_illegal", perf_illegal, exp_ill);
`endif

    // Reset while the instruction is in EXEC.
    send(mk(0, 6, 0, 0, 1, 18'd9));
    tick;
    chk("exec_in_ready", {31'd0, in_ready}, 32'd0);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    model_reset();
    chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_out_res", out_res, 32'd0);
`ifdef ALU_ISSUE_PERF_EN
    chk("rst_perf_retired", perf_retired, 32'd0);
    chk("rst_perf_illegal", perf_illegal, 32'd0);
`endif
    send(mk(0, 7, 6, 0, 1, 18'd0)); recv(0, 0, 0);
    chk("r6_after_rst", last_res, 32'd0);
    send(mk(0, 7, 1, 0, 1, 18'd0)); recv(0, 0, 0);
    chk("r1_after_rst", last_res, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
